// File: rtl/btn_toggle_ctrl.sv
// Push-button conditioner: 2-flop synchronizer, debounce FSM, run/stop toggle,
// and registered one-cycle press / long-hold pulses.
module btn_toggle_ctrl #(
  parameter int   DEBOUNCE_CYCLES = 500_000,
  parameter int   LONG_CYCLES     = 100_000_000,
  parameter logic RESET_ENABLE    = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic enable,
  output logic press_pulse,
  output logic long_pulse,
  output logic btn_level
);

  localparam int CNT_W = $clog2(LONG_CYCLES + 1);
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_MAX  = CNT_W'(LONG_CYCLES);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    RELEASED   = 2'd0,
    PRESS_DB   = 2'd1,
    PRESSED    = 2'd2,
    RELEASE_DB = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic             sync_1, sync_n;
  logic [CNT_W-1:0] db_cnt, db_nxt;
  logic [CNT_W-1:0] hold_cnt, hold_nxt;
  logic             enable_nxt, press_nxt, long_nxt, level_nxt;

  // Both flops reset to the released level so reset never looks like a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_1 <= 1'b1;
      sync_n <= 1'b1;
    end else begin
      sync_1 <= btn_n;
      sync_n <= sync_1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RELEASED;
      db_cnt      <= '0;
      hold_cnt    <= '0;
      enable      <= RESET_ENABLE;
      press_pulse <= 1'b0;
      long_pulse  <= 1'b0;
      btn_level   <= 1'b0;
    end else begin
      state       <= state_nxt;
      db_cnt      <= db_nxt;
      hold_cnt    <= hold_nxt;
      enable      <= enable_nxt;
      press_pulse <= press_nxt;
      long_pulse  <= long_nxt;
      btn_level   <= level_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    db_nxt     = db_cnt;
    hold_nxt   = hold_cnt;
    enable_nxt = enable;
    press_nxt  = 1'b0;
    long_nxt   = 1'b0;
    level_nxt  = btn_level;
    case (state)
      RELEASED: begin
        if (!sync_n) begin
          state_nxt = PRESS_DB;
          db_nxt    = '0;
        end
      end
      PRESS_DB: begin
        if (sync_n) begin
          state_nxt = RELEASED;
        end else if (db_cnt == DB_LAST) begin
          state_nxt  = PRESSED;
          enable_nxt = ~enable;
          press_nxt  = 1'b1;
          level_nxt  = 1'b1;
          hold_nxt   = '0;
        end else begin
          db_nxt = db_cnt + CNT_ONE;
        end
      end
      PRESSED: begin
        if (sync_n) begin
          state_nxt = RELEASE_DB;
          db_nxt    = '0;
        end else if (hold_cnt != LONG_MAX) begin
          // Saturating hold count makes long_pulse fire once per press.
          hold_nxt = hold_cnt + CNT_ONE;
          if (hold_cnt == LONG_LAST) long_nxt = 1'b1;
        end
      end
      RELEASE_DB: begin
        if (!sync_n) begin
          state_nxt = PRESSED;
        end else if (db_cnt == DB_LAST) begin
          state_nxt = RELEASED;
          level_nxt = 1'b0;
        end else begin
          db_nxt = db_cnt + CNT_ONE;
        end
      end
      default: state_nxt = RELEASED;
    endcase
  end

endmodule

// File: tb/tb_btn_toggle_ctrl.sv
// Bench for btn_toggle_ctrl: directed press scenarios plus random bouncing,
// compared cycle by cycle against a run-length debounce reference model.
module tb_btn_toggle_ctrl;

  localparam int   D  = 4;
  localparam int   L  = 20;
  localparam logic RE = 1'b1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_n = 1'b1;
  logic enable, press_pulse, long_pulse, btn_level;

  int total = 0;
  int bad   = 0;

  // Expected {enable, press_pulse, long_pulse, btn_level} after each edge.
  logic [3:0] exp_q[$];

  btn_toggle_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .LONG_CYCLES    (L),
    .RESET_ENABLE   (RE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_n      (btn_n),
    .enable     (enable),
    .press_pulse(press_pulse),
    .long_pulse (long_pulse),
    .btn_level  (btn_level)
  );

  always #5 clk = ~clk;

  // Reference model: the debounced level flips after D+1 consecutive
  // synchronized samples disagreeing with it; hold time counts low samples
  // that follow a low sample while pressed.
  logic p1, p2, prev_s, m_level, m_en;
  int   run, hold;

  always @(posedge clk) begin
    logic s, m_press, m_long;
    m_press = 1'b0;
    m_long  = 1'b0;
    if (rst) begin
      p1 = 1'b1; p2 = 1'b1; prev_s = 1'b1;
      m_level = 1'b0; m_en = RE; run = 0; hold = 0;
    end else begin
      s  = p2;
      p2 = p1;
      p1 = btn_n;
      if (!m_level) begin
        run = s ? 0 : run + 1;
        if (run == D + 1) begin
          m_level = 1'b1; m_en = ~m_en; m_press = 1'b1; run = 0; hold = 0;
        end
      end else if (s) begin
        run = run + 1;
        if (run == D + 1) begin
          m_level = 1'b0; run = 0;
        end
      end else begin
        if (!prev_s && run == 0 && hold < L) begin
          hold = hold + 1;
          if (hold == L) m_long = 1'b1;
        end
        run = 0;
      end
      prev_s = s;
    end
    exp_q.push_back({m_en, m_press, m_long, m_level});
  end

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s t=%0t got en/pp/lp/lvl=%b want=%b", name, $time, got, want);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare against the queue head.
  always @(negedge clk) begin
    logic [3:0] want;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_underflow t=%0t got empty want entry", $time);
    end else begin
      want = exp_q.pop_front();
      check("outputs", {enable, press_pulse, long_pulse, btn_level}, want);
    end
  end

  task automatic drive(input logic level, input int n);
    repeat (n) begin
      @(negedge clk);
      btn_n = level;
    end
  endtask

  // Assert rst at a random phase between an edge and the next falling edge.
  task automatic pulse_reset(input string name);
    @(posedge clk);
    #($urandom_range(1, 3));
    rst = 1'b1;
    exp_q.delete();
    exp_q.push_back({RE, 1'b0, 1'b0, 1'b0});
    #1;
    check(name, {enable, press_pulse, long_pulse, btn_level}, {RE, 1'b0, 1'b0, 1'b0});
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    pulse_reset("reset_async");

    // Clean press: toggle after debounce, no long pulse.
    drive(1'b0, 12);
    drive(1'b1, 10);
    @(negedge clk) #1;
    check("press_toggles", {enable, btn_level}, {~RE, 1'b0});

    // Bounces shorter than the debounce window, then a real press.
    drive(1'b0, 3); drive(1'b1, 1); drive(1'b0, 2); drive(1'b1, 10);
    @(negedge clk) #1;
    check("bounce_rejected", {enable, btn_level}, {~RE, 1'b0});
    drive(1'b0, 10); drive(1'b1, 10);
    @(negedge clk) #1;
    check("second_press", {enable, btn_level}, {RE, 1'b0});

    // Short release glitch mid-press does not re-toggle.
    drive(1'b0, 10); drive(1'b1, 2); drive(1'b0, 10); drive(1'b1, 10);
    @(negedge clk) #1;
    check("glitch_mid_press", {enable, btn_level}, {~RE, 1'b0});

    // Long hold, then release.
    drive(1'b0, 30); drive(1'b1, 10);
    @(negedge clk) #1;
    check("long_hold_release", {enable, btn_level}, {RE, 1'b0});

    // Reset during a press in progress.
    drive(1'b0, 3);
    pulse_reset("reset_mid_press");
    drive(1'b1, 8);
    @(negedge clk) #1;
    check("after_reset", {enable, btn_level}, {RE, 1'b0});

    // Random bouncing, holds and occasional resets.
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 3) == 0)
        drive(1'b0, $urandom_range(22, 34));
      else
        drive(1'(i % 2), $urandom_range(1, 8));
      if ($urandom_range(0, 29) == 0) pulse_reset("reset_random");
    end

    drive(1'b1, 12);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
